// File: rtl/axi_riscv_amo_initiator.sv
// axi_riscv_amo_initiator
//   Turns one RISC-V AMO request at a time into an AXI5 atomic write:
//   AW carries the atop code, a single W beat carries the operand, and the
//   block waits for both R (old value) and B before answering the core.
// Ports
//   clk_i, rst_ni                  clock, async active-low reset
//   req_*                          core request (valid/ready, amo, addr, size, wdata)
//   rsp_*                          core response (valid/ready, rdata, error)
//   mst_aw_*, mst_w_*              AXI write address / data (master side)
//   mst_b_*, mst_r_*               AXI write response / read data (master side)
module axi_riscv_amo_initiator #(
  parameter int unsigned            AXI_ADDR_WIDTH = 32,
  parameter int unsigned            AXI_DATA_WIDTH = 64,
  parameter int unsigned            AXI_ID_WIDTH   = 4,
  parameter logic [AXI_ID_WIDTH-1:0] AXI_ID        = '0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [3:0]                  req_amo_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [1:0]                  req_size_i,
  input  logic [63:0]                 req_wdata_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [63:0]                 rsp_rdata_o,
  output logic                        rsp_error_o,
  output logic [AXI_ADDR_WIDTH-1:0]   mst_aw_addr_o,
  output logic [2:0]                  mst_aw_size_o,
  output logic [5:0]                  mst_aw_atop_o,
  output logic [AXI_ID_WIDTH-1:0]     mst_aw_id_o,
  output logic [7:0]                  mst_aw_len_o,
  output logic [1:0]                  mst_aw_burst_o,
  output logic                        mst_aw_lock_o,
  output logic [3:0]                  mst_aw_cache_o,
  output logic [2:0]                  mst_aw_prot_o,
  output logic [3:0]                  mst_aw_qos_o,
  output logic [3:0]                  mst_aw_region_o,
  output logic                        mst_aw_valid_o,
  input  logic                        mst_aw_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]   mst_w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0] mst_w_strb_o,
  output logic                        mst_w_last_o,
  output logic                        mst_w_valid_o,
  input  logic                        mst_w_ready_i,
  input  logic [1:0]                  mst_b_resp_i,
  input  logic                        mst_b_valid_i,
  output logic                        mst_b_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   mst_r_data_i,
  input  logic [1:0]                  mst_r_resp_i,
  input  logic                        mst_r_valid_i,
  output logic                        mst_r_ready_o
);
  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RSP} state_e;

  state_e                    r_state, w_next;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [OFF_W-1:0]          r_off;
  logic [2:0]                r_aw_size;
  logic [5:0]                r_atop;
  logic [AXI_DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]         r_strb;
  logic                      r_w_last, r_aw_valid, r_w_valid;
  logic                      r_r_seen, r_b_seen, r_err;
  logic [63:0]               r_rdata;

  logic                      w_req_hs, w_aw_hs, w_w_hs, w_r_hs, w_b_hs;
  logic                      w_illegal, w_misalign;
  logic [5:0]                w_atop;
  logic [63:0]               w_opnd, w_rext;
  logic [OFF_W-1:0]          w_off;
  logic [AXI_DATA_WIDTH-1:0] w_wdata, w_rsh;
  logic [STRB_W-1:0]         w_strb;
  logic                      w_unused;

  assign w_req_hs = req_valid_i & req_ready_o;
  assign w_aw_hs  = r_aw_valid & mst_aw_ready_i;
  assign w_w_hs   = r_w_valid & mst_w_ready_i;
  assign w_r_hs   = mst_r_valid_i & mst_r_ready_o;
  assign w_b_hs   = mst_b_valid_i & mst_b_ready_o;

  // Request decode: legality, atop code, and the operand placed on its byte lanes.
  always_comb begin
    w_misalign = req_size_i[0] ? (|req_addr_i[2:0]) : (|req_addr_i[1:0]);
    w_illegal  = (req_amo_i > 4'd8) | ~req_size_i[1] | w_misalign;
    case (req_amo_i)
      4'd0:    w_atop = 6'b110000;  // SWAP
      4'd1:    w_atop = 6'b100000;  // ADD
      4'd2:    w_atop = 6'b100001;  // AND -> CLR
      4'd3:    w_atop = 6'b100011;  // OR  -> SET
      4'd4:    w_atop = 6'b100010;  // XOR -> EOR
      4'd5:    w_atop = 6'b100100;  // MAX -> SMAX
      4'd6:    w_atop = 6'b100110;  // MAXU -> UMAX
      4'd7:    w_atop = 6'b100101;  // MIN -> SMIN
      default: w_atop = 6'b100111;  // MINU -> UMIN
    endcase
    // CLR clears the bits that are set in the operand, so AND needs the complement.
    w_opnd = (req_amo_i == 4'd2) ? ~req_wdata_i : req_wdata_i;
    if (!req_size_i[0]) w_opnd[63:32] = '0;
    w_off   = req_addr_i[OFF_W-1:0];
    w_wdata = AXI_DATA_WIDTH'(w_opnd) << {w_off, 3'b000};
    w_strb  = STRB_W'(req_size_i[0] ? 8'hFF : 8'h0F) << w_off;
  end

  // Legal addresses are size-aligned, so shifting by the full byte offset
  // lands either a .W or a .D result at bit 0.
  assign w_rsh  = mst_r_data_i >> {r_off, 3'b000};
  assign w_rext = r_aw_size[0] ? w_rsh[63:0] : {{32{w_rsh[31]}}, w_rsh[31:0]};

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req_hs) w_next = w_illegal ? S_RSP : S_ISSUE;
      S_ISSUE: if ((~r_aw_valid | w_aw_hs) & (~r_w_valid | w_w_hs)) w_next = S_WAIT;
      S_WAIT:  if ((r_r_seen | w_r_hs) & (r_b_seen | w_b_hs)) w_next = S_RSP;
      S_RSP:   if (rsp_ready_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    req_ready_o   = (r_state == S_IDLE);
    mst_r_ready_o = (r_state == S_ISSUE) | (r_state == S_WAIT);
    mst_b_ready_o = (r_state == S_ISSUE) | (r_state == S_WAIT);
    rsp_valid_o   = (r_state == S_RSP);
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr <= '0; r_off <= '0; r_aw_size <= '0; r_atop <= '0;
      r_wdata <= '0; r_strb <= '0; r_w_last <= 1'b0;
      r_aw_valid <= 1'b0; r_w_valid <= 1'b0;
      r_r_seen <= 1'b0; r_b_seen <= 1'b0; r_err <= 1'b0; r_rdata <= '0;
    end else begin
      if (w_req_hs) begin
        r_rdata  <= '0;
        r_err    <= w_illegal;
        r_r_seen <= 1'b0;
        r_b_seen <= 1'b0;
        if (!w_illegal) begin
          r_addr     <= req_addr_i;
          r_off      <= w_off;
          r_aw_size  <= {1'b0, req_size_i};
          r_atop     <= w_atop;
          r_wdata    <= w_wdata;
          r_strb     <= w_strb;
          r_w_last   <= 1'b1;
          r_aw_valid <= 1'b1;
          r_w_valid  <= 1'b1;
        end
      end
      if (w_aw_hs) r_aw_valid <= 1'b0;
      if (w_w_hs)  r_w_valid  <= 1'b0;
      if (w_r_hs) begin
        r_r_seen <= 1'b1;
        r_rdata  <= w_rext;
        if (mst_r_resp_i[1]) r_err <= 1'b1;
      end
      if (w_b_hs) begin
        r_b_seen <= 1'b1;
        if (mst_b_resp_i[1]) r_err <= 1'b1;
      end
    end
  end

  assign rsp_rdata_o     = r_rdata;
  assign rsp_error_o     = r_err;
  assign mst_aw_addr_o   = r_addr;
  assign mst_aw_size_o   = r_aw_size;
  assign mst_aw_atop_o   = r_atop;
  assign mst_aw_id_o     = AXI_ID;
  assign mst_aw_len_o    = 8'd0;
  assign mst_aw_burst_o  = 2'b01;
  assign mst_aw_lock_o   = 1'b0;
  assign mst_aw_cache_o  = 4'd0;
  assign mst_aw_prot_o   = 3'd0;
  assign mst_aw_qos_o    = 4'd0;
  assign mst_aw_region_o = 4'd0;
  assign mst_aw_valid_o  = r_aw_valid;
  assign mst_w_data_o    = r_wdata;
  assign mst_w_strb_o    = r_strb;
  assign mst_w_last_o    = r_w_last;
  assign mst_w_valid_o   = r_w_valid;

  // Only the error bit of each response matters; OKAY vs EXOKAY is irrelevant here.
  assign w_unused = ^{mst_b_resp_i[0], mst_r_resp_i[0], w_rsh};
endmodule

// File: tb/tb_axi_riscv_amo_initiator.sv
module tb_axi_riscv_amo_initiator;
  localparam int AW = 32, DW = 64, IW = 4;
  localparam logic [IW-1:0] TID = 4'h5;

  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic req_valid_i = 0, req_ready_o;
  logic [3:0] req_amo_i = '0;
  logic [AW-1:0] req_addr_i = '0;
  logic [1:0] req_size_i = '0;
  logic [63:0] req_wdata_i = '0;
  logic rsp_valid_o, rsp_ready_i = 0, rsp_error_o;
  logic [63:0] rsp_rdata_o;
  logic [AW-1:0] mst_aw_addr_o;
  logic [2:0] mst_aw_size_o, mst_aw_prot_o;
  logic [5:0] mst_aw_atop_o;
  logic [IW-1:0] mst_aw_id_o;
  logic [7:0] mst_aw_len_o;
  logic [1:0] mst_aw_burst_o;
  logic mst_aw_lock_o;
  logic [3:0] mst_aw_cache_o, mst_aw_qos_o, mst_aw_region_o;
  logic mst_aw_valid_o, mst_aw_ready_i = 0;
  logic [DW-1:0] mst_w_data_o;
  logic [DW/8-1:0] mst_w_strb_o;
  logic mst_w_last_o, mst_w_valid_o, mst_w_ready_i = 0;
  logic [1:0] mst_b_resp_i = '0;
  logic mst_b_valid_i = 0, mst_b_ready_o;
  logic [DW-1:0] mst_r_data_i = '0;
  logic [1:0] mst_r_resp_i = '0;
  logic mst_r_valid_i = 0, mst_r_ready_o;

  typedef struct {logic [63:0] rdata; logic err;} rsp_t;
  typedef struct {logic [AW-1:0] addr; logic [5:0] atop; logic [2:0] size;} aw_t;
  typedef struct {logic [63:0] data; logic [7:0] strb;} w_t;
  rsp_t rsp_q[$];
  aw_t  aw_q[$];
  w_t   w_q[$];
  int g_checks = 0, g_errors = 0;

  always #5 clk_i = ~clk_i;

  axi_riscv_amo_initiator #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .AXI_ID(TID)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_amo_i(req_amo_i),
    .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o), .rsp_error_o(rsp_error_o),
    .mst_aw_addr_o(mst_aw_addr_o), .mst_aw_size_o(mst_aw_size_o), .mst_aw_atop_o(mst_aw_atop_o),
    .mst_aw_id_o(mst_aw_id_o), .mst_aw_len_o(mst_aw_len_o), .mst_aw_burst_o(mst_aw_burst_o),
    .mst_aw_lock_o(mst_aw_lock_o), .mst_aw_cache_o(mst_aw_cache_o), .mst_aw_prot_o(mst_aw_prot_o),
    .mst_aw_qos_o(mst_aw_qos_o), .mst_aw_region_o(mst_aw_region_o),
    .mst_aw_valid_o(mst_aw_valid_o), .mst_aw_ready_i(mst_aw_ready_i),
    .mst_w_data_o(mst_w_data_o), .mst_w_strb_o(mst_w_strb_o), .mst_w_last_o(mst_w_last_o),
    .mst_w_valid_o(mst_w_valid_o), .mst_w_ready_i(mst_w_ready_i),
    .mst_b_resp_i(mst_b_resp_i), .mst_b_valid_i(mst_b_valid_i), .mst_b_ready_o(mst_b_ready_o),
    .mst_r_data_i(mst_r_data_i), .mst_r_resp_i(mst_r_resp_i), .mst_r_valid_i(mst_r_valid_i),
    .mst_r_ready_o(mst_r_ready_o)
  );

  function automatic logic [5:0] model_atop(input logic [3:0] amo);
    case (amo)
      4'd0: return 6'h30; 4'd1: return 6'h20; 4'd2: return 6'h21; 4'd3: return 6'h23;
      4'd4: return 6'h22; 4'd5: return 6'h24; 4'd6: return 6'h26; 4'd7: return 6'h25;
      default: return 6'h27;
    endcase
  endfunction

  // One AMO through the DUT with a scripted slave. Delays/cycles are relative
  // to the request-accept edge (cycle 0).
  task automatic run_txn(input string nm, input logic [3:0] amo, input logic [AW-1:0] addr,
                         input logic [1:0] size, input logic [63:0] wd,
                         input int aw_dly, input int w_dly, input int r_cyc, input int b_cyc,
                         input logic [63:0] rd, input logic [1:0] rresp, input logic [1:0] bresp,
                         input int rsp_dly);
    logic illegal; logic [63:0] op, mask; rsp_t er; aw_t ea; w_t ew;
    int t, exp_lat, aw_cnt, w_cnt, first;
    bit r_done, b_done, rsp_done;
    illegal = (amo > 4'd8) || (size < 2'd2) || ((size == 2'd2) ? (addr[1:0] != 0) : (addr[2:0] != 0));
    if (illegal) begin
      er.rdata = '0; er.err = 1'b1; exp_lat = 1;
    end else begin
      er.err = rresp[1] | bresp[1];
      if (size == 2'd3) er.rdata = rd;
      else er.rdata = addr[2] ? {{32{rd[63]}}, rd[63:32]} : {{32{rd[31]}}, rd[31:0]};
      exp_lat = 1 + ((r_cyc > b_cyc) ? r_cyc : b_cyc);
      op = (amo == 4'd2) ? ~wd : wd;
      ea.addr = addr; ea.atop = model_atop(amo); ea.size = {1'b0, size};
      if (size == 2'd3) begin ew.data = op; ew.strb = 8'hFF; end
      else if (addr[2]) begin ew.data = {op[31:0], 32'h0}; ew.strb = 8'hF0; end
      else begin ew.data = {32'h0, op[31:0]}; ew.strb = 8'h0F; end
      aw_q.push_back(ea); w_q.push_back(ew);
    end
    rsp_q.push_back(er);
    aw_cnt = 0; w_cnt = 0; first = -1; r_done = 0; b_done = 0; rsp_done = 0;

    @(posedge clk_i); #1;
    req_valid_i = 1; req_amo_i = amo; req_addr_i = addr; req_size_i = size; req_wdata_i = wd;
    @(negedge clk_i);
    g_checks++; if (req_ready_o !== 1'b1) begin g_errors++; $display("FAIL %s req_ready got %b want 1", nm, req_ready_o); end
    @(posedge clk_i); #1;
    req_valid_i = 0; t = 1;
    while (!rsp_done && t < 60) begin
      mst_aw_ready_i = (t >= 1 + aw_dly);
      mst_w_ready_i  = (t >= 1 + w_dly);
      mst_r_valid_i  = !illegal && !r_done && (t >= r_cyc);
      mst_r_data_i   = rd; mst_r_resp_i = rresp;
      mst_b_valid_i  = !illegal && !b_done && (t >= b_cyc);
      mst_b_resp_i   = bresp;
      rsp_ready_i    = (t >= exp_lat + rsp_dly);
      @(negedge clk_i);
      g_checks++; if (req_ready_o !== 1'b0) begin g_errors++; $display("FAIL %s busy_req_ready t=%0d got %b want 0", nm, t, req_ready_o); end
      if (t == 1) begin
        g_checks++;
        if ({mst_aw_valid_o, mst_w_valid_o} !== {2{!illegal}}) begin
          g_errors++; $display("FAIL %s issue_latency aw/w valid got %b%b want %b", nm, mst_aw_valid_o, mst_w_valid_o, !illegal);
        end
      end
      if (mst_aw_valid_o) begin
        aw_cnt++; g_checks++;
        if (aw_q.size() == 0) begin g_errors++; $display("FAIL %s aw_unexpected got addr %h want none", nm, mst_aw_addr_o); end
        else begin
          if ({mst_aw_addr_o, mst_aw_atop_o, mst_aw_size_o, mst_aw_id_o} !== {aw_q[0].addr, aw_q[0].atop, aw_q[0].size, TID}) begin
            g_errors++; $display("FAIL %s aw_payload got addr %h atop %h size %0d id %h want addr %h atop %h size %0d id %h",
              nm, mst_aw_addr_o, mst_aw_atop_o, mst_aw_size_o, mst_aw_id_o, aw_q[0].addr, aw_q[0].atop, aw_q[0].size, TID);
          end
          if (mst_aw_ready_i) void'(aw_q.pop_front());
        end
      end
      if (mst_w_valid_o) begin
        w_cnt++; g_checks++;
        if (w_q.size() == 0) begin g_errors++; $display("FAIL %s w_unexpected got data %h want none", nm, mst_w_data_o); end
        else begin
          for (int b = 0; b < 8; b++) mask[8*b +: 8] = {8{w_q[0].strb[b]}};
          if ({mst_w_data_o & mask, mst_w_strb_o, mst_w_last_o} !== {w_q[0].data, w_q[0].strb, 1'b1}) begin
            g_errors++; $display("FAIL %s w_payload got data %h strb %h last %b want data %h strb %h last 1",
              nm, mst_w_data_o & mask, mst_w_strb_o, mst_w_last_o, w_q[0].data, w_q[0].strb);
          end
          if (mst_w_ready_i) void'(w_q.pop_front());
        end
      end
      if (mst_r_valid_i && mst_r_ready_o) r_done = 1;
      if (mst_b_valid_i && mst_b_ready_o) b_done = 1;
      if (rsp_valid_o) begin
        if (first < 0) begin
          first = t; g_checks++;
          if (first != exp_lat) begin g_errors++; $display("FAIL %s rsp_latency got %0d want %0d", nm, first, exp_lat); end
        end
        g_checks++;
        if ({rsp_rdata_o, rsp_error_o} !== {rsp_q[0].rdata, rsp_q[0].err}) begin
          g_errors++; $display("FAIL %s rsp t=%0d got rdata %h err %b want rdata %h err %b",
            nm, t, rsp_rdata_o, rsp_error_o, rsp_q[0].rdata, rsp_q[0].err);
        end
        if (rsp_ready_i) begin void'(rsp_q.pop_front()); rsp_done = 1; end
      end
      @(posedge clk_i); #1;
      t++;
    end
    mst_aw_ready_i = 0; mst_w_ready_i = 0; mst_r_valid_i = 0; mst_b_valid_i = 0; rsp_ready_i = 0;
    g_checks++; if (!rsp_done) begin g_errors++; $display("FAIL %s timeout got no response want one within 60 cycles", nm); end
    g_checks++;
    if (aw_cnt != (illegal ? 0 : aw_dly + 1) || w_cnt != (illegal ? 0 : w_dly + 1)) begin
      g_errors++; $display("FAIL %s valid_cycles got aw %0d w %0d want aw %0d w %0d", nm, aw_cnt, w_cnt,
        illegal ? 0 : aw_dly + 1, illegal ? 0 : w_dly + 1);
    end
    g_checks++;
    if (aw_q.size() + w_q.size() + rsp_q.size() != 0) begin
      g_errors++; $display("FAIL %s leftover got aw %0d w %0d rsp %0d want 0", nm, aw_q.size(), w_q.size(), rsp_q.size());
    end
    aw_q.delete(); w_q.delete(); rsp_q.delete();
    // Exactly one response: nothing more may follow.
    @(negedge clk_i);
    g_checks++; if (rsp_valid_o !== 1'b0) begin g_errors++; $display("FAIL %s extra_rsp got %b want 0", nm, rsp_valid_o); end
  endtask

  task automatic check_reset_outputs(input string nm);
    g_checks++;
    if ({req_ready_o, mst_aw_valid_o, mst_w_valid_o, mst_r_ready_o, mst_b_ready_o, rsp_valid_o, rsp_error_o} !== 7'b1000000 ||
        rsp_rdata_o !== 64'h0 || mst_aw_addr_o !== '0 || mst_aw_atop_o !== 6'h0 || mst_aw_size_o !== 3'h0 ||
        mst_w_data_o !== '0 || mst_w_strb_o !== '0 || mst_w_last_o !== 1'b0) begin
      g_errors++;
      $display("FAIL %s outputs got ctl %b rdata %h addr %h atop %h data %h strb %h last %b want ctl 1000000 rest 0", nm,
        {req_ready_o, mst_aw_valid_o, mst_w_valid_o, mst_r_ready_o, mst_b_ready_o, rsp_valid_o, rsp_error_o},
        rsp_rdata_o, mst_aw_addr_o, mst_aw_atop_o, mst_w_data_o, mst_w_strb_o, mst_w_last_o);
    end
  endtask

  task automatic test_reset();
    #2 check_reset_outputs("reset");
    repeat (2) @(negedge clk_i);
    rst_ni = 1;
    @(negedge clk_i);
    check_reset_outputs("reset_release");
  endtask

  task automatic test_add_w();
    run_txn("add_w", 4'd1, 32'h1004, 2'd2, 64'h1, 0, 0, 2, 2, 64'hFFFFFFFF_00000000, 2'b00, 2'b00, 0);
  endtask

  task automatic test_and_d();
    run_txn("and_d", 4'd2, 32'h2000, 2'd3, 64'h00FF, 0, 0, 3, 2, 64'h0123_4567_89AB_CDEF, 2'b00, 2'b00, 0);
  endtask

  task automatic test_swap_order();
    run_txn("swap_b_first", 4'd0, 32'h3008, 2'd3, 64'hDEAD_BEEF_CAFE_F00D, 0, 0, 5, 2, 64'h8000_0000_0000_0001, 2'b00, 2'b00, 0);
    run_txn("swap_same", 4'd0, 32'h3010, 2'd3, 64'h1111_2222_3333_4444, 0, 0, 2, 2, 64'h5555_6666_7777_8888, 2'b00, 2'b00, 0);
  endtask

  task automatic test_aw_stall();
    run_txn("aw_stall", 4'd3, 32'h1000, 2'd2, 64'h0000_0000_8000_00F0, 4, 0, 6, 6, 64'h1234_5678_9ABC_DEF0, 2'b00, 2'b10, 0);
  endtask

  task automatic test_ops();
    logic [3:0] ops [5] = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    for (int i = 0; i < 5; i++) begin
      run_txn("op_w", ops[i], 32'h4000 + 32'(i * 4), 2'd2, {$urandom, $urandom}, 0, 1, 3, 2, {$urandom, $urandom}, 2'b00, 2'b00, 1);
      run_txn("op_d", ops[i], 32'h5000 + 32'(i * 8), 2'd3, {$urandom, $urandom}, 1, 0, 3, 4, {$urandom, $urandom}, 2'b01, 2'b00, 0);
    end
  endtask

  task automatic test_illegal();
    run_txn("ill_amo", 4'd9, 32'h2000, 2'd3, 64'h5, 0, 0, 2, 2, 64'h0, 2'b00, 2'b00, 5);
    run_txn("ill_align", 4'd1, 32'h1004, 2'd3, 64'h5, 0, 0, 2, 2, 64'h0, 2'b00, 2'b00, 0);
    run_txn("ill_size", 4'd0, 32'h1000, 2'd1, 64'h5, 0, 0, 2, 2, 64'h0, 2'b00, 2'b00, 0);
    run_txn("rslverr", 4'd1, 32'h1008, 2'd3, 64'h7, 0, 0, 2, 2, 64'h42, 2'b10, 2'b00, 0);
  endtask

  task automatic test_reset_wait();
    @(posedge clk_i); #1;
    req_valid_i = 1; req_amo_i = 4'd4; req_addr_i = 32'h6000; req_size_i = 2'd3; req_wdata_i = 64'hF0F0;
    mst_aw_ready_i = 1; mst_w_ready_i = 1;
    @(posedge clk_i); #1;
    req_valid_i = 0;
    @(posedge clk_i); #1;
    mst_aw_ready_i = 0; mst_w_ready_i = 0;
    @(negedge clk_i);
    g_checks++;
    if ({mst_r_ready_o, mst_aw_valid_o, mst_w_valid_o, rsp_valid_o} !== 4'b1000) begin
      g_errors++; $display("FAIL rst_wait state got r_ready/aw/w/rsp %b want 1000",
        {mst_r_ready_o, mst_aw_valid_o, mst_w_valid_o, rsp_valid_o});
    end
    #1 rst_ni = 0;
    #1 check_reset_outputs("rst_wait");
    @(negedge clk_i);
    rst_ni = 1;
    run_txn("after_rst", 4'd1, 32'h7000, 2'd2, 64'hFFFF_FFFF, 0, 0, 2, 3, 64'h0000_0000_7FFF_FFFF, 2'b00, 2'b00, 0);
  endtask

  initial begin
    test_reset();
    test_add_w();
    test_and_d();
    test_swap_order();
    test_aw_stall();
    test_ops();
    test_illegal();
    test_reset_wait();
    $display("CHECKS %0d ERRORS %0d", g_checks, g_errors);
    $finish;
  end
endmodule
